// File: rtl/fb_rect_writer.sv
// Rectangle fill engine: clips a command to the visible area, then writes one
// pixel per unstalled cycle in raster order (x inner, y outer).
module fb_rect_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk_d,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  x0,
    input  logic [9:0]  x1,
    input  logic [9:0]  y0,
    input  logic [9:0]  y1,
    input  logic [11:0] color,
    input  logic        wr_stall,
    output logic [19:0] ram_addr,
    output logic [11:0] ram_din,
    output logic        ram_we,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

    state_t      r_state;
    logic [9:0]  r_x0, r_x1, r_y0, r_y1;
    logic [9:0]  r_x, r_y;
    logic [11:0] r_color;
    logic        r_ready, r_busy, r_done, r_err;

    logic [9:0]  w_x1c, w_y1c;
    logic        w_reject, w_we;

    assign w_x1c    = (r_x1 > X_MAX) ? X_MAX : r_x1;
    assign w_y1c    = (r_y1 > Y_MAX) ? Y_MAX : r_y1;
    assign w_reject = (r_x0 > w_x1c) || (r_y0 > w_y1c) || (r_x0 > X_MAX) || (r_y0 > Y_MAX);
    assign w_we     = (r_state == WRITE) && !wr_stall;

    assign ram_we    = w_we;
    assign ram_addr  = {r_x, r_y};
    assign ram_din   = r_color;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

    always_ff @(posedge clk_d or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // ready rises on the first edge out of reset, so no accept on that edge
                    r_ready <= 1'b1;
                    if (cmd_valid && r_ready) begin
                        r_x0    <= x0;
                        r_x1    <= x1;
                        r_y0    <= y0;
                        r_y1    <= y1;
                        r_color <= color;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_err <= w_reject;
                    r_x1  <= w_x1c;
                    r_y1  <= w_y1c;
                    r_x   <= r_x0;
                    r_y   <= r_y0;
                    if (w_reject) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (!wr_stall) begin
                        if (r_x == r_x1) begin
                            if (r_y == r_y1) begin
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end else begin
                                r_x <= r_x0;
                                r_y <= r_y + 10'd1;
                            end
                        end else begin
                            r_x <= r_x + 10'd1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Randomized bench for fb_rect_writer: each command is checked against a
// clip-and-enumerate reference of the pixels it must write.
module tb_fb_rect_writer;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk_d = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  x0, x1, y0, y1;
    logic [11:0] color;
    logic        wr_stall;
    logic [19:0] ram_addr;
    logic [11:0] ram_din;
    logic        ram_we, busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    fb_rect_writer #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_d(clk_d), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .wr_stall(wr_stall),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // stall_mode: 0 none, 1 random, 2 stall cycles 3..5 after acceptance.
    // hold: keep cmd_valid high with junk fields while busy. imm: must be accepted at once.
    task automatic run_cmd(input int ax0, input int ax1, input int ay0, input int ay1,
                           input logic [11:0] col, input int stall_mode,
                           input bit hold, input bit imm);
        logic [19:0] exq[$];
        bit rej, fin;
        int cx1, cy1, n, widx, stalls, waitc;
        cx1 = (ax1 > H - 1) ? H - 1 : ax1;
        cy1 = (ay1 > V - 1) ? V - 1 : ay1;
        rej = (ax0 > cx1) || (ay0 > cy1) || (ax0 >= H) || (ay0 >= V);
        if (!rej)
            for (int yy = ay0; yy <= cy1; yy++)
                for (int xx = ax0; xx <= cx1; xx++)
                    exq.push_back({10'(xx), 10'(yy)});
        n = exq.size();

        cmd_valid = 1'b1;
        x0 = 10'(ax0); x1 = 10'(ax1); y0 = 10'(ay0); y1 = 10'(ay1);
        color = col;
        wr_stall = 1'b0;
        waitc = 0;
        #1;
        while (!cmd_ready && waitc < 200) begin
            @(negedge clk_d); #1;
            waitc++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        if (imm) chk("b2b_accept_wait", waitc, 0);
        @(posedge clk_d);

        widx = 0; stalls = 0; fin = 0;
        for (int k = 1; k <= 3000 && !fin; k++) begin
            @(negedge clk_d);
            if (k == 1) begin
                if (hold) begin
                    x0 = 10'($urandom); x1 = 10'($urandom);
                    y0 = 10'($urandom); y1 = 10'($urandom);
                    color = 12'($urandom);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            case (stall_mode)
                1:       wr_stall = ($urandom_range(0, 3) == 0);
                2:       wr_stall = (k >= 3 && k <= 5);
                default: wr_stall = 1'b0;
            endcase
            #1;
            chk("ready_while_busy", cmd_ready, 0);
            chk("busy_while_busy", busy, 1);
            if (wr_stall && k >= 2 && !rej && widx < n) begin
                stalls++;
                chk("we_in_stall", ram_we, 0);
                chk("addr_in_stall", ram_addr, exq[widx]);
            end
            if (ram_we) begin
                if (widx < n) begin
                    chk("addr", ram_addr, exq[widx]);
                    chk("din", ram_din, col);
                end else begin
                    chk("extra_write", 1, 0);
                end
                widx++;
            end
            if (done) begin
                fin = 1;
                chk("err", err, rej);
                chk("nwrites", widx, n);
                chk("done_cycle", k, rej ? 2 : n + 2 + stalls);
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        wr_stall = 1'b0;
        @(negedge clk_d); #1;
        chk("done_pulse_len", done, 0);
        chk("busy_after_done", busy, 0);
        chk("ready_after_done", cmd_ready, 1);
        chk("err_holds", err, rej);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc, kind, a0, a1, b0, b1;
        rst_n = 1'b0; cmd_valid = 1'b0; wr_stall = 1'b0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
        #1;
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", cmd_ready, 0);
        repeat (3) @(negedge clk_d);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", cmd_ready, 0);
        @(negedge clk_d); #1;
        chk("ready_after_reset", cmd_ready, 1);

        run_cmd(10, 12, 5, 6, 12'hF00, 0, 0, 0);
        run_cmd(638, 700, 479, 900, 12'h0F0, 0, 0, 0);
        run_cmd(20, 10, 0, 0, 12'h00F, 0, 0, 0);
        run_cmd(0, 3, 0, 0, 12'h123, 2, 0, 0);
        run_cmd(7, 7, 9, 9, 12'h456, 0, 0, 0);
        run_cmd(5, 6, 7, 7, 12'h789, 0, 1, 0);
        run_cmd(100, 101, 200, 201, 12'hABC, 0, 0, 1);

        // Reset in the middle of a 4x4 fill
        cmd_valid = 1'b1;
        x0 = 10'd0; x1 = 10'd3; y0 = 10'd0; y1 = 10'd3; color = 12'hDEF;
        #1 chk("mid_rst_ready", cmd_ready, 1);
        @(posedge clk_d);
        wc = 0;
        for (int k = 0; k < 20 && wc < 2; k++) begin
            @(negedge clk_d);
            cmd_valid = 1'b0;
            #1;
            if (ram_we) wc++;
        end
        chk("mid_rst_writes_seen", wc, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_we", ram_we, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", ram_addr, 0);
        repeat (2) @(negedge clk_d);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_d); #1;
            chk("post_rst_we", ram_we, 0);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_ready", cmd_ready, 1);
        end
        run_cmd(0, 0, 0, 0, 12'h321, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                a0 = $urandom_range(0, H - 1); a1 = a0 + $urandom_range(0, 7);
                b0 = $urandom_range(0, V - 1); b1 = b0 + $urandom_range(0, 5);
            end else if (kind == 6) begin
                a0 = $urandom_range(1, H - 1); a1 = $urandom_range(0, a0 - 1);
                b0 = $urandom_range(0, V - 1); b1 = b0;
            end else if (kind == 7) begin
                a0 = $urandom_range(0, H - 1); a1 = a0;
                b0 = $urandom_range(V, 1023); b1 = $urandom_range(b0, 1023);
            end else if (kind == 8) begin
                a0 = $urandom_range(H - 8, H - 1); a1 = $urandom_range(H, 1023);
                b0 = $urandom_range(V - 6, V - 1); b1 = $urandom_range(V, 1023);
            end else begin
                a0 = $urandom_range(H, 1023); a1 = 1023;
                b0 = $urandom_range(0, V - 1); b1 = b0;
            end
            run_cmd(a0, a1, b0, b1, 12'($urandom), $urandom_range(0, 1),
                    1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
